// File: rtl/final_debounce.sv
// Push-button debouncer: 2-flop sync, 4-state qualify FSM, registered outputs.
// Define FINAL_DEBOUNCE_REPEAT_EN to add auto-repeat dips while held.
module final_debounce #(
  parameter int STABLE_CYCLES = 20000,
  parameter int CNT_W         = 16,
  parameter int HOLD_CYCLES   = 500000,
  parameter int REPEAT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic button_raw,
  output logic button_clean,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE,
    CHK_PRESS,
    PRESSED,
    CHK_RELEASE
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic             clean_q, clean_d;
  logic             busy_q, busy_d;
  logic             dip;
  logic             sync;

`ifdef FINAL_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             rep_q, rep_d;
  logic [CNT_W-1:0] lim;

  assign lim = rep_q ? REP_LAST : HOLD_LAST;

  always_ff @(posedge clk) begin
    if (rst) rep_q <= 1'b0;
    else     rep_q <= rep_d;
  end
`endif

  assign sync = sync_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dip     = 1'b0;
`ifdef FINAL_DEBOUNCE_REPEAT_EN
    rep_d   = rep_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = CHK_PRESS;
          cnt_d   = ONE;
        end
      end
      CHK_PRESS: begin
        if (!sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_d = CHK_RELEASE;
          cnt_d   = ONE;
`ifdef FINAL_DEBOUNCE_REPEAT_EN
          rep_d   = 1'b0;
        end else if (cnt_q == lim) begin
          // first dip after the hold time, then every repeat period
          dip   = 1'b1;
          cnt_d = '0;
          rep_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ONE;
`endif
        end
      end
      CHK_RELEASE: begin
        if (sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    clean_d = ((state_d == PRESSED) || (state_d == CHK_RELEASE)) && !dip;
    busy_d  = (state_d == CHK_PRESS) || (state_d == CHK_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b00;
      state_q <= IDLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], button_raw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      busy_q  <= busy_d;
    end
  end

  assign button_clean = clean_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_final_debounce.sv
// Bench for final_debounce: vector table, corner sequences, random vs run-length model.
// Honours FINAL_DEBOUNCE_REPEAT_EN the same way as the design.
module tb_final_debounce;

  localparam int STABLE = 4;
  localparam int HOLD   = 10;
  localparam int REP    = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button_raw = 1'b0;
  logic button_clean;
  logic busy;

  int checks = 0;
  int errors = 0;

  // reference model: sync delay line plus run length of samples opposing clean
  int m_s0, m_s1, m_clean, m_run, m_held, m_dip;

  final_debounce #(
    .STABLE_CYCLES(STABLE),
    .CNT_W(8),
    .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button_raw(button_raw),
    .button_clean(button_clean),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_update(input logic r, input logic raw);
    int s;
    if (r) begin
      m_s0 = 0; m_s1 = 0; m_clean = 0;
      m_run = 0; m_held = 0; m_dip = 0;
    end else begin
      s = m_s1;
      m_s1 = m_s0;
      m_s0 = int'(raw);
      m_dip = 0;
      if (s != m_clean) begin
        m_run++;
        if (m_run == STABLE) begin
          m_clean = s;
          m_run = 0;
          m_held = 0;
        end
      end else begin
        if (m_clean == 1 && m_run > 0) m_held = 0;
        else if (m_clean == 1) begin
          m_held++;
`ifdef FINAL_DEBOUNCE_REPEAT_EN
          if (m_held >= HOLD && (m_held - HOLD) % REP == 0) m_dip = 1;
`endif
        end
        m_run = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic raw);
    rst = r;
    button_raw = raw;
    @(posedge clk);
    m_update(r, raw);
    #1;
    chk("model_clean", int'(button_clean), (m_clean == 1 && m_dip == 0) ? 1 : 0);
    chk("model_busy", int'(busy), (m_run > 0) ? 1 : 0);
  endtask

  typedef struct {
    logic r;
    logic raw;
    logic clean;
    logic bsy;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int first;
    int dips;
    int rose;
    int lvl;
    int len;

    tbl[0]  = '{1, 1, 0, 0};
    tbl[1]  = '{1, 1, 0, 0};
    tbl[2]  = '{1, 1, 0, 0};
    tbl[3]  = '{0, 1, 0, 0};
    tbl[4]  = '{0, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 1};
    tbl[6]  = '{0, 1, 0, 1};
    tbl[7]  = '{0, 1, 0, 1};
    tbl[8]  = '{0, 1, 1, 0};
    tbl[9]  = '{0, 1, 1, 0};
    tbl[10] = '{0, 0, 1, 0};
    tbl[11] = '{0, 0, 1, 0};
    tbl[12] = '{0, 0, 1, 1};
    tbl[13] = '{0, 0, 1, 1};
    tbl[14] = '{0, 0, 1, 1};
    tbl[15] = '{0, 0, 0, 0};

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].r, tbl[i].raw);
      chk($sformatf("tbl%0d_clean", i), int'(button_clean), int'(tbl[i].clean));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].bsy));
    end

    // short press: never reaches clean
    for (int i = 0; i < 3; i++) begin
      step(0, 1);
      chk("short_clean", int'(button_clean), 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0);
      chk("short_clean", int'(button_clean), 0);
    end
    chk("short_busy_end", int'(busy), 0);

    // release glitch while pressed, then a real release
    for (int i = 0; i < 8; i++) step(0, 1);
    chk("glitch_pressed", int'(button_clean), 1);
    for (int i = 0; i < 2; i++) begin
      step(0, 0);
      chk("glitch_hold", int'(button_clean), 1);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 1);
      chk("glitch_hold", int'(button_clean), 1);
    end
    for (int i = 0; i < 6; i++) begin
      step(0, 0);
      if (i == 4) chk("release_e5", int'(button_clean), 1);
      if (i == 5) chk("release_e6", int'(button_clean), 0);
    end

    // reset in the middle of press qualification
    for (int i = 0; i < 4; i++) step(0, 1);
    chk("mid_busy", int'(busy), 1);
    step(1, 1);
    chk("rst_mid_clean", int'(button_clean), 0);
    chk("rst_mid_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) step(0, 0);

    // long hold: auto-repeat dips
    step(1, 0);
    rose = 0;
    for (int i = 0; i < 20 && rose == 0; i++) begin
      step(0, 1);
      if (button_clean) rose = 1;
    end
    chk("hold_rose", rose, 1);
    dips = 0;
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      step(0, 1);
      if (!button_clean) begin
        dips++;
        if (first < 0) first = k;
      end
    end
`ifdef FINAL_DEBOUNCE_REPEAT_EN
    chk("dip_count", dips, 7);
    chk("dip_first", first, HOLD);
`else
    chk("dip_count", dips, 0);
    chk("dip_first", first, -1);
`endif
    for (int i = 0; i < 8; i++) step(0, 0);

    // random segments against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        step(1, 1'($urandom_range(0, 1)));
      end else begin
        lvl = int'($urandom_range(0, 1));
        len = (n % 25 == 0) ? 30 : int'($urandom_range(1, 12));
        for (int j = 0; j < len; j++) step(0, lvl[0]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
